// File: rtl/seq_bin2bcd.sv
// rtl/seq_bin2bcd.sv - iterative double-dabble binary to packed BCD converter
module seq_bin2bcd #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [BIN_W-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  valid_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic [DIGITS-1:0]     blank_o
);

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   localparam int              SCR_W = 4 * DIGITS;
   localparam int              CNT_W = $clog2(BIN_W);
   localparam longint unsigned MAX_V = (64'd1 << BIN_W) - 64'd1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
      $fatal(1, "seq_bin2bcd: BIN_W must be within 4..32");
   end
   if (pow10(DIGITS) <= MAX_V) begin : g_bad_digits
      $fatal(1, "seq_bin2bcd: DIGITS too small for BIN_W");
   end

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [BIN_W-1:0]  shreg_q;
   logic [SCR_W-1:0]  scr_q;
   logic [SCR_W-1:0]  corr;
   logic [SCR_W-1:0]  scr_nxt;
   logic [DIGITS-1:0] blank_nxt;
   logic              last_iter;

   assign last_iter = (state_q == SHIFT) && (cnt_q == LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i)   state_d = SHIFT;
         SHIFT:   if (last_iter) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == SHIFT);
   end

   // Add-3 correction per digit precedes the shift; digits never carry into each other.
   always_comb begin
      corr = scr_q;
      for (int n = 0; n < DIGITS; n++) begin
         if (scr_q[4*n +: 4] >= 4'd5) corr[4*n +: 4] = scr_q[4*n +: 4] + 4'd3;
      end
      scr_nxt = (corr << 1) | {{(SCR_W-1){1'b0}}, shreg_q[BIN_W-1]};
   end

   always_comb begin
      logic zero_run;
      zero_run  = 1'b1;
      blank_nxt = '0;
      for (int n = DIGITS - 1; n >= 1; n--) begin
         zero_run     = zero_run & (scr_nxt[4*n +: 4] == 4'd0);
         blank_nxt[n] = zero_run;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         shreg_q <= '0;
         scr_q   <= '0;
         done_o  <= 1'b0;
         valid_o <= 1'b0;
         bcd_o   <= '0;
         blank_o <= BLANK_RST;
      end else begin
         done_o <= last_iter;
         if (state_q == IDLE) begin
            if (start_i) begin
               shreg_q <= bin_i;
               scr_q   <= '0;
               cnt_q   <= '0;
            end
         end else begin
            shreg_q <= shreg_q << 1;
            scr_q   <= scr_nxt;
            cnt_q   <= cnt_q + 1'b1;
         end
         // Visible outputs move only on the final iteration.
         if (last_iter) begin
            bcd_o   <= scr_nxt;
            blank_o <= blank_nxt;
            valid_o <= 1'b1;
         end
      end
   end

endmodule
